// File: rtl/uart_byte_rx.sv
// ---------------------------------------------------------------------------
// uart_byte_rx
//
// Receives 8-bit UART characters (LSB first, optional parity, one stop bit)
// from an asynchronous serial line. Each good byte is presented on rx_data
// together with a single-cycle rx_data_valid strobe. Corrupted characters
// produce a single-cycle error strobe instead and leave rx_data untouched.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit period (>= 4)
//   PARITY        0 = none, 1 = odd, 2 = even
//
// Ports
//   clk            in   rising-edge system clock
//   rst_n          in   synchronous active-low reset
//   rx             in   asynchronous serial line, idle high
//   rx_data        out  last correctly received byte (held)
//   rx_data_valid  out  1-cycle strobe: rx_data is new this cycle
//   rx_frame_err   out  1-cycle strobe: stop bit sampled low
//   rx_parity_err  out  1-cycle strobe: parity mismatch, stop bit good
//   rx_busy        out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // Last count of a full bit period and of the half period used to
    // re-check the start bit at its centre.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic PAR_ODD = (PARITY == 1);
    localparam logic PAR_EN  = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_RECOVER
    } state_t;

    // Two-flop synchronizer; both stages come out of reset as "line idle".
    logic             rx_meta_q;
    logic             rx_s_q;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             par_err_q, par_err_d;
    logic [7:0]       data_q,    data_d;
    logic             valid_q,   valid_d;
    logic             ferr_q,    ferr_d;
    logic             perr_q,    perr_d;

    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d   = S_START;
                    par_err_d = 1'b0;
                end
            end

            S_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        // Start bit still low at its centre: from here on
                        // every sample lands mid-bit.
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        // Too short to be a start bit; drop it silently.
                        state_d = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d     = '0;
                    // LSB arrives first, so shift in from the top.
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PAR_EN ? S_PAR : S_STOP;
                    end
                end
            end

            S_PAR: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d     = '0;
                    // XOR over data+parity must be 1 for odd, 0 for even;
                    // a mismatch is held until the stop bit decides.
                    par_err_d = (^shift_q) ^ rx_s_q ^ PAR_ODD;
                    state_d   = S_STOP;
                end
            end

            S_STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                        if (par_err_q) begin
                            perr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
                    end else begin
                        // A bad stop bit overrides any parity verdict.
                        ferr_d  = 1'b1;
                        state_d = S_RECOVER;
                    end
                end
            end

            S_RECOVER: begin
                // Wait out a break: a held-low line must not look like a
                // stream of new start bits.
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        rx_busy       = (state_q != S_IDLE);
        rx_data       = data_q;
        rx_data_valid = valid_q;
        rx_frame_err  = ferr_q;
        rx_parity_err = perr_q;
    end

endmodule
